fp_mul_seq: RTL and testbench

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

---
 rtl/fp_mul_pkg.sv | 37 +++
 rtl/fp_mul_mant_seq.sv | 51 +++++
 rtl/fp_mul_seq.sv | 172 +++++++++++++++++
 tb/tb_fp_mul_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types, flag indices and encoding helpers for the sequential FP multiplier.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    // Encodings are returned 64 bits wide; callers keep the low W bits.
    function automatic logic [63:0] fp_bias(input int exp_w);
        return (64'd1 << (exp_w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fp_exp_ones(input int exp_w);
        return (64'd1 << exp_w) - 64'd1;
    endfunction

    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return (fp_exp_ones(exp_w) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
        return fp_exp_ones(exp_w) << man_w;
    endfunction

    function automatic logic [63:0] fp_zero(input int exp_w, input int man_w, input logic sign);
        return {63'd0, sign} << (exp_w + man_w);
    endfunction

endpackage

// File: rtl/fp_mul_mant_seq.sv
// Shift-add significand multiplier: one multiplier bit per cycle, N cycles per product.
module fp_mul_mant_seq
#(
    parameter int N = 24
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic [2*N-1:0]   product,
    output logic             last
);

    localparam int            CW       = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    logic [2*N-1:0] mcand_r;
    logic [N-1:0]   mplier_r;
    logic [CW-1:0]  cnt_r;
    logic           active_r;

    // Operand load and one shift-add iteration per active cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= {(2*N){1'b0}};
            mplier_r <= {N{1'b0}};
            product  <= {(2*N){1'b0}};
            cnt_r    <= {CW{1'b0}};
            active_r <= 1'b0;
        end else if (load) begin
            mcand_r  <= {{N{1'b0}}, multiplicand};
            mplier_r <= multiplier;
            product  <= {(2*N){1'b0}};
            cnt_r    <= {CW{1'b0}};
            active_r <= 1'b1;
        end else if (active_r) begin
            if (mplier_r[0]) begin
                product <= product + mcand_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            active_r <= (cnt_r != LAST_CNT);
        end
    end

    assign last = active_r && (cnt_r == LAST_CNT);

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754-format multiplier: special-case bypass, shift-add significand,
// single-cycle normalise/round-to-nearest-even/range check.
module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         done,
    output logic         busy,
    output logic [3:0]   flags
);

    localparam int XW = EXP_W + 2;
    localparam logic [63:0]      BIAS64   = fp_bias(EXP_W);
    localparam logic [63:0]      ONES64   = fp_exp_ones(EXP_W);
    localparam logic [63:0]      QNAN64   = fp_qnan(EXP_W, MAN_W);
    localparam logic [63:0]      INF64    = fp_inf(EXP_W, MAN_W);
    localparam logic [63:0]      ZERO64   = fp_zero(EXP_W, MAN_W, 1'b0);
    localparam logic [XW-1:0]    BIAS_X   = BIAS64[XW-1:0];
    localparam logic [XW-1:0]    EMAX_X   = ONES64[XW-1:0];
    localparam logic [EXP_W-1:0] EXP_ONES = ONES64[EXP_W-1:0];
    localparam logic [W-1:0]     QNAN     = QNAN64[W-1:0];
    localparam logic [W-1:0]     INF      = INF64[W-1:0];
    localparam logic [W-1:0]     ZERO     = ZERO64[W-1:0];

    state_t             state_r, next_s;
    logic               sign_r;
    logic [EXP_W-1:0]   ea_r, eb_r;

    logic [EXP_W-1:0]   ea_s, eb_s;
    logic               a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;
    logic               special_s, sign_s, accept_s, load_s, last_s;
    logic [W-1:0]       spec_result_s, norm_result_s;
    logic [3:0]         spec_flags_s, norm_flags_s;

    logic [2*MAN_W+1:0] prod_s;
    logic               n_s, guard_s, round_s, sticky_s, inc_s, inexact_s;
    logic [2*MAN_W:0]   norm_s;
    logic [MAN_W:0]     frac_sum_s;
    logic [XW-1:0]      exp_s;

    assign ea_s     = a[W-2:MAN_W];
    assign eb_s     = b[W-2:MAN_W];
    assign a_zero_s = (ea_s == {EXP_W{1'b0}});
    assign b_zero_s = (eb_s == {EXP_W{1'b0}});
    assign a_inf_s  = (ea_s == EXP_ONES) && (a[MAN_W-1:0] == {MAN_W{1'b0}});
    assign b_inf_s  = (eb_s == EXP_ONES) && (b[MAN_W-1:0] == {MAN_W{1'b0}});
    assign a_nan_s  = (ea_s == EXP_ONES) && (a[MAN_W-1:0] != {MAN_W{1'b0}});
    assign b_nan_s  = (eb_s == EXP_ONES) && (b[MAN_W-1:0] != {MAN_W{1'b0}});
    assign special_s = a_zero_s | a_inf_s | a_nan_s | b_zero_s | b_inf_s | b_nan_s;
    assign sign_s    = a[W-1] ^ b[W-1];
    assign accept_s  = (state_r == IDLE) && start;
    assign load_s    = accept_s && !special_s;

    fp_mul_mant_seq #(.N(MAN_W + 1)) u_mant (
        .clk          (clk),
        .rst          (rst),
        .load         (load_s),
        .multiplicand ({1'b1, a[MAN_W-1:0]}),
        .multiplier   ({1'b1, b[MAN_W-1:0]}),
        .product      (prod_s),
        .last         (last_s)
    );

    // Special operand results, resolved directly at the accepting edge
    always_comb begin
        spec_result_s = {sign_s, ZERO[W-2:0]};
        spec_flags_s  = 4'b0000;
        if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (a_zero_s && b_inf_s)) begin
            spec_result_s               = QNAN;
            spec_flags_s[FLAG_INVALID]  = 1'b1;
        end else if (a_inf_s || b_inf_s) begin
            spec_result_s = {sign_s, INF[W-2:0]};
        end else begin
            spec_result_s = {sign_s, ZERO[W-2:0]};
        end
    end

    // A product in [2,4) drops one bit; otherwise the leading one sits at bit 2*MAN_W
    assign n_s        = prod_s[2*MAN_W+1];
    assign norm_s     = n_s ? prod_s[2*MAN_W:0] : {prod_s[2*MAN_W-1:0], 1'b0};
    assign guard_s    = norm_s[MAN_W];
    assign round_s    = norm_s[MAN_W-1];
    assign sticky_s   = |norm_s[MAN_W-2:0];
    assign inc_s      = guard_s & (round_s | sticky_s | norm_s[MAN_W+1]);
    assign inexact_s  = guard_s | round_s | sticky_s;
    assign frac_sum_s = {1'b0, norm_s[2*MAN_W:MAN_W+1]} + {{MAN_W{1'b0}}, inc_s};
    assign exp_s      = {2'b00, ea_r} + {2'b00, eb_r} - BIAS_X
                      + {{(XW-1){1'b0}}, n_s} + {{(XW-1){1'b0}}, frac_sum_s[MAN_W]};

    // Range check and final packing of the normal-path result
    always_comb begin
        norm_result_s = {sign_r, ZERO[W-2:0]};
        norm_flags_s  = 4'b0000;
        if ($signed(exp_s) >= $signed(EMAX_X)) begin
            norm_result_s                = {sign_r, INF[W-2:0]};
            norm_flags_s[FLAG_OVERFLOW]  = 1'b1;
            norm_flags_s[FLAG_INEXACT]   = 1'b1;
        end else if ($signed(exp_s) <= $signed({XW{1'b0}})) begin
            norm_result_s                = {sign_r, ZERO[W-2:0]};
            norm_flags_s[FLAG_UNDERFLOW] = 1'b1;
            norm_flags_s[FLAG_INEXACT]   = 1'b1;
        end else begin
            norm_result_s                = {sign_r, exp_s[EXP_W-1:0], frac_sum_s[MAN_W-1:0]};
            norm_flags_s[FLAG_INEXACT]   = inexact_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_s = special_s ? DONE : MUL;
                end else begin
                    next_s = IDLE;
                end
            end
            MUL: begin
                if (last_s) begin
                    next_s = NORM;
                end else begin
                    next_s = MUL;
                end
            end
            NORM:    next_s = DONE;
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State, captured exponents/sign and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sign_r  <= 1'b0;
            ea_r    <= {EXP_W{1'b0}};
            eb_r    <= {EXP_W{1'b0}};
            result  <= {W{1'b0}};
            flags   <= 4'b0000;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_r <= next_s;
            done    <= (next_s == DONE);
            busy    <= (next_s != IDLE);
            if (accept_s) begin
                sign_r <= sign_s;
                ea_r   <= ea_s;
                eb_r   <= eb_s;
            end
            if (accept_s && special_s) begin
                result <= spec_result_s;
                flags  <= spec_flags_s;
            end else if (state_r == NORM) begin
                result <= norm_result_s;
                flags  <= norm_flags_s;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench: binary32 and binary16 instances against an integer-arithmetic reference.
module tb_fp_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, go, cur;
    logic [31:0] op_a, op_b;
    logic        start32, start16, done32, done16, busy32, busy16;
    logic [31:0] result32;
    logic [15:0] result16;
    logic [3:0]  flags32, flags16;
    logic        done_m, busy_m;
    logic [31:0] result_m;
    logic [3:0]  flags_m;

    int n_checks = 0;
    int n_pass   = 0;

    assign start32  = go & ~cur;
    assign start16  = go & cur;
    assign done_m   = cur ? done16 : done32;
    assign busy_m   = cur ? busy16 : busy32;
    assign result_m = cur ? {16'h0000, result16} : result32;
    assign flags_m  = cur ? flags16 : flags32;

    fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(op_a), .b(op_b),
        .result(result32), .done(done32), .busy(busy32), .flags(flags32)
    );

    fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(op_a[15:0]), .b(op_b[15:0]),
        .result(result16), .done(done16), .busy(busy16), .flags(flags16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    // Returns {special, flags[3:0], result[31:0]} from exact integer product and RNE by remainder.
    function automatic logic [36:0] ref_mul(input int ew, input int mw, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ones, fa, fb, ea, eb, ma, mb, prod, q, rem, half, sgn, res;
        longint e;
        int w, sh;
        logic za, zb, ia, ib, na, nb, inx;
        w    = 1 + ew + mw;
        ones = (64'd1 << ew) - 64'd1;
        sgn  = (a[w-1] ^ b[w-1]) ? (64'd1 << (w - 1)) : 64'd0;
        ea   = ({32'd0, a} >> mw) & ones;
        eb   = ({32'd0, b} >> mw) & ones;
        fa   = {32'd0, a} & ((64'd1 << mw) - 64'd1);
        fb   = {32'd0, b} & ((64'd1 << mw) - 64'd1);
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == ones) && (fa == 0); ib = (eb == ones) && (fb == 0);
        na = (ea == ones) && (fa != 0); nb = (eb == ones) && (fb != 0);
        if (na || nb || (ia && zb) || (za && ib)) begin
            res = (ones << mw) | (64'd1 << (mw - 1));
            return {1'b1, 4'b1000, res[31:0]};
        end
        if (ia || ib) begin
            res = sgn | (ones << mw);
            return {1'b1, 4'b0000, res[31:0]};
        end
        if (za || zb) return {1'b1, 4'b0000, sgn[31:0]};
        ma   = fa | (64'd1 << mw);
        mb   = fb | (64'd1 << mw);
        prod = ma * mb;
        e    = longint'(ea) + longint'(eb) - ((longint'(1) << (ew - 1)) - 1);
        if (prod >= (64'd1 << (2 * mw + 1))) begin sh = mw + 1; e++; end
        else sh = mw;
        q    = prod >> sh;
        rem  = prod - (q << sh);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << (mw + 1))) begin q = q >> 1; e++; end
        if (e >= longint'(ones)) begin
            res = sgn | (ones << mw);
            return {1'b0, 4'b0101, res[31:0]};
        end
        if (e <= 0) return {1'b0, 4'b0011, sgn[31:0]};
        res = sgn | (longint'(e) << mw) | (q - (64'd1 << mw));
        return {1'b0, 3'b000, inx, res[31:0]};
    endfunction

    // Latency counts edges from the accepting edge (1) up to the edge after which done is seen.
    task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] b, input int poke,
                          output logic [31:0] res, output logic [3:0] fl, output int lat);
        @(negedge clk);
        cur = sel; op_a = a; op_b = b; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; lat = 1;
        while (!done_m && lat < 100) begin
            if (lat == poke) begin op_a = 32'h7F800000; op_b = 32'h00000000; go = 1'b1; end
            else go = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        go = 1'b0;
        res = result_m; fl = flags_m;
        @(posedge clk); #1;
        check("done_pulse", done_m, 1'b0);
    endtask

    function automatic logic [31:0] rand_op(input logic sel);
        int r;
        logic [31:0] e, f, s;
        r = $urandom_range(0, 19);
        s = $urandom_range(0, 1);
        f = sel ? $urandom_range(0, 1023) : ($urandom & 32'h007FFFFF);
        if (r == 0) e = 0;
        else if (r == 1) begin
            e = sel ? 31 : 255;
            if ($urandom_range(0, 1) == 0) f = 0;
        end else e = sel ? $urandom_range(1, 30) : $urandom_range(40, 214);
        return sel ? ((s << 15) | (e << 10) | f) : ((s << 31) | (e << 23) | f);
    endfunction

    logic [31:0] da [7] = '{32'h40400000, 32'h40000000, 32'h3F800001, 32'h7F800000, 32'h7FC00001, 32'h7F000000, 32'h00800000};
    logic [31:0] db [7] = '{32'h3FC00000, 32'hBF000000, 32'h3F800001, 32'h00000000, 32'h3F800000, 32'h7F000000, 32'h00800000};
    logic [31:0] dr [7] = '{32'h40900000, 32'hBF800000, 32'h3F800002, 32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
    logic [3:0]  df [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b1000, 4'b0101, 4'b0011};
    int          dl [7] = '{26, 26, 26, 1, 1, 26, 26};

    initial begin
        logic [31:0] res, ra, rb;
        logic [3:0]  fl;
        logic [36:0] want;
        int          lat, wait_n;
        logic        sel;

        rst = 1'b1; go = 1'b0; cur = 1'b0; op_a = 32'h0; op_b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result32, 32'h0);
        check("rst_flags", flags32, 4'h0);
        check("rst_done", done32, 1'b0);
        check("rst_busy", busy32, 1'b0);
        check("rst_product", dut32.u_mant.product, 48'h0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(1'b0, da[i], db[i], 0, res, fl, lat);
            check($sformatf("dir%0d_result", i), res, dr[i]);
            check($sformatf("dir%0d_flags", i), fl, df[i]);
            check($sformatf("dir%0d_latency", i), lat, dl[i]);
        end

        run_op(1'b1, 32'h00004200, 32'h00003E00, 0, res, fl, lat);
        check("half_result", res, 32'h00004480);
        check("half_flags", fl, 4'h0);
        check("half_latency", lat, 13);

        // A start pulse during MUL must not disturb or re-queue
        run_op(1'b0, 32'h40400000, 32'h3FC00000, 5, res, fl, lat);
        check("busy_start_result", res, 32'h40900000);
        check("busy_start_latency", lat, 26);
        repeat (3) @(posedge clk);
        #1;
        check("busy_start_no_requeue_done", done32, 1'b0);
        check("busy_start_no_requeue_busy", busy32, 1'b0);

        // Reset in the middle of MUL
        @(negedge clk);
        cur = 1'b0; op_a = 32'h40400000; op_b = 32'h3FC00000; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_busy_before_rst", busy32, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", busy32, 1'b0);
        check("mid_rst_done", done32, 1'b0);
        check("mid_rst_result", result32, 32'h0);
        check("mid_rst_product", dut32.u_mant.product, 48'h0);

        // Start coincident with reset is ignored
        @(negedge clk);
        rst = 1'b1; go = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; go = 1'b0;
        check("start_in_rst_busy", busy32, 1'b0);

        run_op(1'b0, 32'h40000000, 32'hBF000000, 0, res, fl, lat);
        check("after_rst_result", res, 32'hBF800000);
        check("after_rst_latency", lat, 26);

        // Start held high through DONE is re-accepted on the first IDLE cycle
        @(negedge clk);
        cur = 1'b0; op_a = 32'h40400000; op_b = 32'h3FC00000; go = 1'b1;
        @(posedge clk); #1;
        wait_n = 1;
        while (!done32 && wait_n < 100) begin @(posedge clk); #1; wait_n++; end
        check("held_first_latency", wait_n, 26);
        @(posedge clk); #1;
        check("held_idle_busy", busy32, 1'b0);
        @(posedge clk); #1;
        check("held_reaccept_busy", busy32, 1'b1);
        go = 1'b0;
        wait_n = 0;
        while (busy32 && wait_n < 100) begin @(posedge clk); #1; wait_n++; end
        check("held_second_result", result32, 32'h40900000);

        for (int i = 0; i < 160; i++) begin
            sel  = (i % 4 == 3);
            ra   = rand_op(sel);
            rb   = rand_op(sel);
            want = sel ? ref_mul(5, 10, ra, rb) : ref_mul(8, 23, ra, rb);
            run_op(sel, ra, rb, 0, res, fl, lat);
            check($sformatf("rnd%0d_result a=%h b=%h", i, ra, rb), res, want[31:0]);
            check($sformatf("rnd%0d_flags a=%h b=%h", i, ra, rb), fl, want[35:32]);
            check($sformatf("rnd%0d_latency", i), lat, want[36] ? 1 : (sel ? 13 : 26));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
